// File: rtl/mips_sequencer_if.sv
// Memory-bus handshake, decoder feedback and sequencer status for the MIPS multicycle core.
interface mips_sequencer_if;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        mem_read;
  logic        mem_write;
  logic        extra;
  logic        halt_req;
  logic [1:0]  state;
  logic [31:0] instruction;
  logic        active;
  logic        stall;
  logic        retire;
  logic [31:0] instr_retired;

  modport master (
    output waitrequest, readdata, mem_read, mem_write, extra, halt_req,
    input  state, instruction, active, stall, retire, instr_retired
  );

  modport slave (
    input  waitrequest, readdata, mem_read, mem_write, extra, halt_req,
    output state, instruction, active, stall, retire, instr_retired
  );
endinterface

// File: rtl/mips_sequencer.sv
// Multicycle control sequencer: FETCH/EXEC1/EXEC2/HALT state, instruction register,
// waitrequest stalls and a retired-instruction counter.
module mips_sequencer #(
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] instr_retired_q, instr_retired_d;
  logic        active_q, active_d;
  logic        stall, retire;
  logic        mem_op;

  assign mem_op = bus.mem_read | bus.mem_write;

  // Each branch reads only the inputs meaningful in its state, so unsampled inputs cannot leak.
  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    stall         = 1'b0;
    retire        = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.waitrequest) begin
          stall = 1'b1;
        end else begin
          instruction_d = bus.readdata;
          state_d       = EXEC1;
        end
      end
      EXEC1: begin
        if (mem_op && bus.waitrequest) begin
          stall = 1'b1;
        end else if (bus.extra) begin
          state_d = EXEC2;
        end else begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXEC2: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: ;
    endcase
    active_d        = (state_d != HALT);
    instr_retired_d = instr_retired_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FETCH;
      instruction_q   <= IR_RESET;
      instr_retired_q <= 32'd0;
      active_q        <= 1'b1;
    end else begin
      state_q         <= state_d;
      instruction_q   <= instruction_d;
      instr_retired_q <= instr_retired_d;
      active_q        <= active_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.instruction   = instruction_q;
  assign bus.active        = active_q;
  assign bus.stall         = stall;
  assign bus.retire        = retire;
  assign bus.instr_retired = instr_retired_q;

endmodule

// File: doc/mips_sequencer.md
# mips_sequencer

Multicycle control sequencer for the MIPS CPU core. It owns the 2-bit `state` register (FETCH/EXEC1/EXEC2/HALT) consumed by `mips_decoder`, the instruction register, and the memory-bus waitrequest handshake. It also keeps a retired-instruction counter. It sits between the Avalon-style memory port and the decoder: its `instruction` output feeds the decoder, and the decoder's `MemRead`/`MemWrite`/`Extra`/`Halt` outputs feed back into it.

## Interface
- `IR_RESET`, default 32'h0000_0000: instruction register value after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `waitrequest`  in  1  memory busy; the current access has not completed.
- `readdata`  in  32  memory read data.
- `mem_read`  in  1  decoder `MemRead` (sampled in EXEC1 only).
- `mem_write`  in  1  decoder `MemWrite` (sampled in EXEC1 only).
- `extra`  in  1  decoder `Extra`: the instruction needs EXEC2 (sampled in EXEC1 only).
- `halt_req`  in  1  decoder `Halt` (PC == 0) (sampled in FETCH only).
- `state`  out  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT; registered.
- `instruction`  out  32  instruction register; registered.
- `active`  out  1  1 unless `state` == HALT; registered.
- `stall`  out  1  combinational: the current state is held this cycle because of `waitrequest`.
- `retire`  out  1  combinational: one-cycle pulse, the instruction completes this cycle.
- `instr_retired`  out  32  count of retired instructions; registered.

## Operation
- Reset (`rst_n`=0, asynchronous, takes effect immediately, including mid-access):
  - `state`=00
  - `instruction`=`IR_RESET`
  - `active`=1
  - `instr_retired`=0
  - Any outstanding access is abandoned. No pending-request state survives.
- FETCH (00):
  - If `halt_req`=1: go to HALT. Instruction register unchanged. `halt_req` has priority over `waitrequest`.
  - Else if `waitrequest`=1: stay in FETCH, `stall`=1.
  - Else: load `instruction` <= `readdata` and go to EXEC1.
- EXEC1 (01):
  - Let `mem_op` = `mem_read` | `mem_write`.
  - If `mem_op` & `waitrequest`: stay in EXEC1, `stall`=1. `instruction` is held, so the decoder outputs stay stable.
  - Else if `extra`: go to EXEC2.
  - Else: go to FETCH with `retire`=1.
- EXEC2 (10): exactly one cycle, always go to FETCH with `retire`=1. `waitrequest` is ignored (no access is issued in EXEC2).
- HALT (11):
  - Absorbing; only `rst_n` leaves it.
  - `active`=0, `stall`=0, `retire`=0.
  - `instruction` and `instr_retired` are frozen.
- `instr_retired` increments by 1 on every cycle with `retire`=1. It is modulo 2^32 and wraps FFFF_FFFF -> 0000_0000.
- `stall` = (FETCH & !`halt_req` & `waitrequest`) | (EXEC1 & `mem_op` & `waitrequest`).
- Inputs not sampled in the current state (including X) must not affect any output.

## Timing
- Minimum instruction latency:
  - 2 cycles (FETCH, EXEC1) for non-`extra` instructions.
  - 3 cycles (FETCH, EXEC1, EXEC2) for `extra` instructions.
- Each cycle of `waitrequest`=1 in FETCH, or in EXEC1 with `mem_op`, adds exactly one cycle. There is no timeout.
- `instruction` becomes valid in the first EXEC1 cycle, the cycle after the FETCH edge where `waitrequest`=0.
- `retire` and the `instr_retired` increment are coincident: the counter shows the new value on the cycle after `retire`.
- `extra` with a stall: remain in EXEC1 until `waitrequest`=0, then go to EXEC2. EXEC2 is never skipped.
- `halt_req` takes effect the edge after it is seen in FETCH. `active` falls together with `state` becoming 11.
- Release of `rst_n` is synchronised externally. The first active edge after release evaluates FETCH.

## Test plan
- Reset and simple fetch:
  - Stimulus: assert `rst_n`=0 mid-EXEC1 with `waitrequest`=1.
  - Required: `state`=00, `instruction`=0, `instr_retired`=0, `active`=1 immediately, without waiting for a clock edge.
  - Then release `rst_n`, drive `readdata`=32'h2408_0005 with `waitrequest`=0, then `extra`=0.
  - Required: FETCH -> EXEC1 -> FETCH, `instruction`=32'h2408_0005, one `retire` pulse, `instr_retired`=1.
- Fetch stall: hold `waitrequest`=1 for 3 cycles in FETCH -> `state` stays 00 with `stall`=1 for 3 cycles; IR loaded on the 4th edge; total latency 5 cycles.
- Load with data stall: in EXEC1 drive `mem_read`=1, `extra`=1, `waitrequest`=1 for 2 cycles -> EXEC1 held 3 cycles, then EXEC2 for 1 cycle, then FETCH; `retire` pulses only on the EXEC2 cycle.
- Store without stall: `mem_write`=1, `extra`=0, `waitrequest`=0 -> EXEC1 for 1 cycle then FETCH. Then `mem_read`=0, `mem_write`=0, `waitrequest`=1 in EXEC1 -> no stall.
- Halt: `halt_req`=1 in FETCH with `waitrequest`=1 -> `state`=11, `active`=0 next cycle; IR and counter frozen for 10 cycles of arbitrary inputs; only `rst_n` recovers.
- Counter wrap: run until `instr_retired`=FFFF_FFFF (the bench may force it), retire one more instruction -> `instr_retired`=0000_0000.
